// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared definitions for the LFSR sequencing controller: FSM encoding and
// default LFSR geometry (3-bit maximal-length sequence, period 7).
package lfsr_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int         LFSR_WIDTH    = 3;
    localparam logic [3:1] LFSR_TAPS     = 3'b101;
    localparam logic [3:1] LFSR_DEF_SEED = 3'b110;
    localparam int         LFSR_CNT_W    = 8;

endpackage

// File: rtl/lfsr_seq_ctrl_core.sv
// Fibonacci LFSR register: shift toward the MSB, XOR of tapped bits enters q[1].
// A load request takes priority over a step request.
module lfsr_core
    import lfsr_seq_ctrl_pkg::*;
#(
    parameter int               WIDTH   = LFSR_WIDTH,
    parameter logic [WIDTH:1]   TAPS    = LFSR_TAPS,
    parameter logic [WIDTH:1]   RST_VAL = LFSR_DEF_SEED
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH:1]   load_val,
    input  logic             step,
    output logic [WIDTH:1]   q
);

    logic [WIDTH:1] q_r;
    logic [WIDTH:1] q_next_s;

    function automatic logic feedback_bit(input logic [WIDTH:1] v);
        return ^(v & TAPS);
    endfunction

    // Next state of the shift register for one step.
    always_comb begin
        q_next_s = {q_r[WIDTH-1:1], feedback_bit(q_r)};
    end

    // State register: clear, then load, then step, else hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r <= RST_VAL;
        end else if (load) begin
            q_r <= load_val;
        end else if (step) begin
            q_r <= q_next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller around lfsr_core: guarded seed load, counted runs over a
// valid/ready stream, wrap/period measurement and zero-seed lockup reporting.
module lfsr_seq_ctrl
    import lfsr_seq_ctrl_pkg::*;
#(
    parameter int               WIDTH    = LFSR_WIDTH,
    parameter logic [WIDTH:1]   TAPS     = LFSR_TAPS,
    parameter logic [WIDTH:1]   DEF_SEED = LFSR_DEF_SEED,
    parameter int               CNT_W    = LFSR_CNT_W
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               seed_we,
    input  logic [WIDTH:1]     seed,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_steps,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH:1]     out_data,
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic [CNT_W-1:0]   period,
    output logic               lockup
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_e        state_r;
    seq_state_e        state_next_s;
    logic [WIDTH:1]    seed_reg_r;
    logic [CNT_W-1:0]  remaining_r;
    logic [CNT_W-1:0]  period_cnt_r;
    logic [CNT_W-1:0]  period_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              wrap_r;
    logic              lockup_r;

    logic [WIDTH:1]    lfsr_q_s;
    logic [WIDTH:1]    q_next_s;
    logic              load_s;
    logic [WIDTH:1]    load_val_s;
    logic              step_s;
    logic              hs_s;
    logic              seed_zero_s;
    logic              seed_load_s;
    logic              run_start_s;
    logic              wrap_hit_s;

    function automatic logic feedback_bit(input logic [WIDTH:1] v);
        return ^(v & TAPS);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    lfsr_core #(
        .WIDTH   (WIDTH),
        .TAPS    (TAPS),
        .RST_VAL (DEF_SEED)
    ) u_core (
        .clk      (clk),
        .clr      (clr),
        .load     (load_s),
        .load_val (load_val_s),
        .step     (step_s),
        .q        (lfsr_q_s)
    );

    assign hs_s        = out_valid_r & out_ready;
    assign seed_zero_s = (seed == {WIDTH{1'b0}});
    assign q_next_s    = {lfsr_q_s[WIDTH-1:1], feedback_bit(lfsr_q_s)};
    assign wrap_hit_s  = step_s & (q_next_s == seed_reg_r);

    // FSM next state plus core load/step controls.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_val_s   = DEF_SEED;
        step_s       = 1'b0;
        seed_load_s  = 1'b0;
        run_start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (seed_we) begin
                    load_s      = 1'b1;
                    seed_load_s = 1'b1;
                    load_val_s  = seed_zero_s ? DEF_SEED : seed;
                end else begin
                    load_s      = 1'b0;
                end
                if (start) begin
                    run_start_s  = 1'b1;
                    state_next_s = (num_steps != {CNT_W{1'b0}}) ? ST_RUN : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Only an accepted beat advances the generator.
                if (hs_s) begin
                    step_s       = 1'b1;
                    state_next_s = (remaining_r == CNT_ONE) ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, registered status outputs, counters and seed storage.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r      <= ST_IDLE;
            seed_reg_r   <= DEF_SEED;
            remaining_r  <= {CNT_W{1'b0}};
            period_cnt_r <= {CNT_W{1'b0}};
            period_r     <= {CNT_W{1'b0}};
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            wrap_r       <= 1'b0;
            lockup_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == ST_RUN);
            busy_r      <= (state_next_s == ST_RUN);
            done_r      <= (state_next_s == ST_DONE);
            wrap_r      <= wrap_hit_s;
            lockup_r    <= seed_load_s & seed_zero_s;

            // A new seed restarts the period measurement.
            if (seed_load_s) begin
                seed_reg_r   <= load_val_s;
                period_cnt_r <= {CNT_W{1'b0}};
            end else if (wrap_hit_s) begin
                period_r     <= sat_inc(period_cnt_r);
                period_cnt_r <= {CNT_W{1'b0}};
            end else if (step_s) begin
                period_cnt_r <= sat_inc(period_cnt_r);
            end else begin
                period_cnt_r <= period_cnt_r;
            end

            if (run_start_s) begin
                remaining_r <= num_steps;
            end else if (step_s) begin
                remaining_r <= remaining_r - CNT_ONE;
            end else begin
                remaining_r <= remaining_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = lfsr_q_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign wrap      = wrap_r;
    assign period    = period_r;
    assign lockup    = lockup_r;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed self-checking bench for lfsr_seq_ctrl with hand-computed sequences.
module tb_lfsr_seq_ctrl;

    logic       clk;
    logic       clr;
    logic       seed_we;
    logic [3:1] seed;
    logic       start;
    logic [7:0] num_steps;
    logic       out_ready;
    logic       out_valid;
    logic [3:1] out_data;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [7:0] period;
    logic       lockup;

    int checks = 0;
    int errors = 0;

    // Full period from 110 with taps 101: q1'=q1^q3, q2'=q1, q3'=q2.
    localparam logic [3:1] SEQ [0:7] = '{3'b110, 3'b101, 3'b010, 3'b100,
                                         3'b001, 3'b011, 3'b111, 3'b110};

    lfsr_seq_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .seed_we   (seed_we),
        .seed      (seed),
        .start     (start),
        .num_steps (num_steps),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .period    (period),
        .lockup    (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; seed_we = 1'b0; seed = 3'b000; start = 1'b0;
        num_steps = 8'd0; out_ready = 1'b0;
        tick();
        tick();
        clr = 1'b0;
        checks++;
        if ({out_valid, busy, done, wrap, lockup} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {out_valid, busy, done, wrap, lockup});
        end
        checks++;
        if (out_data !== 3'b110 || period !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got data=%b period=%0d expected 110/0", out_data, period);
        end
    endtask

    task automatic test_full_period(input string tag);
        start = 1'b1; num_steps = 8'd7; out_ready = 1'b1;
        tick();
        start = 1'b0; num_steps = 8'd2;  // must not affect the running count
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== SEQ[i] || wrap !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_beat%0d: got v=%b b=%b data=%b wrap=%b done=%b expected 1/1/%b/0/0",
                         tag, i, out_valid, busy, out_data, wrap, done, SEQ[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || wrap !== 1'b1 || period !== 8'd7 || out_data !== 3'b110) begin
            errors++;
            $display("FAIL %s_end: got done=%b v=%b busy=%b wrap=%b period=%0d data=%b expected 1/0/0/1/7/110",
                     tag, done, out_valid, busy, wrap, period, out_data);
        end
        tick();
        checks++;
        if (done !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got done=%b wrap=%b busy=%b v=%b expected 0/0/0/0", tag, done, wrap, busy, out_valid);
        end
    endtask

    task automatic test_seed_load();
        logic [3:1] exp [0:2];
        exp[0] = 3'b001; exp[1] = 3'b011; exp[2] = 3'b111;
        seed_we = 1'b1; seed = 3'b001;
        tick();
        seed_we = 1'b0;
        checks++;
        if (out_data !== 3'b001 || lockup !== 1'b0) begin
            errors++;
            $display("FAIL seed_load: got data=%b lockup=%b expected 001/0", out_data, lockup);
        end
        start = 1'b1; num_steps = 8'd3; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || wrap !== 1'b0) begin
                errors++;
                $display("FAIL seed_beat%0d: got v=%b data=%b wrap=%b expected 1/%b/0", i, out_valid, out_data, wrap, exp[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || wrap !== 1'b0 || out_data !== 3'b110 || period !== 8'd7) begin
            errors++;
            $display("FAIL seed_end: got done=%b wrap=%b data=%b period=%0d expected 1/0/110/7", done, wrap, out_data, period);
        end
        tick();
    endtask

    task automatic test_zero_seed();
        seed_we = 1'b1; seed = 3'b000;
        tick();
        seed_we = 1'b0;
        checks++;
        if (lockup !== 1'b1 || out_data !== 3'b110) begin
            errors++;
            $display("FAIL lockup_pulse: got lockup=%b data=%b expected 1/110", lockup, out_data);
        end
        tick();
        checks++;
        if (lockup !== 1'b0) begin
            errors++;
            $display("FAIL lockup_clear: got %b expected 0", lockup);
        end
        test_full_period("zero_seed_run");
    endtask

    task automatic test_backpressure();
        int hs = 0;
        int c  = 0;
        start = 1'b1; num_steps = 8'd4; out_ready = 1'b0;
        tick();
        start = 1'b0;
        while (hs < 4 && c < 20) begin
            out_ready = (c % 3 == 0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== SEQ[hs]) begin
                errors++;
                $display("FAIL bp_cycle%0d: got v=%b data=%b expected 1/%b", c, out_valid, out_data, SEQ[hs]);
            end
            tick();
            if (out_ready) hs++;
            c++;
        end
        out_ready = 1'b1;
        checks++;
        if (hs !== 4 || c !== 10) begin
            errors++;
            $display("FAIL bp_budget: got hs=%0d cycles=%0d expected 4/10", hs, c);
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || out_data !== 3'b001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: got done=%b v=%b data=%b wrap=%b expected 1/0/001/0", done, out_valid, out_data, wrap);
        end
        tick();
    endtask

    task automatic test_clr_midrun();
        // lfsr continues from 001 left by the previous run.
        start = 1'b1; num_steps = 8'd7; out_ready = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (out_data !== 3'b001 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat0: got data=%b v=%b expected 001/1", out_data, out_valid);
        end
        seed_we = 1'b1; seed = 3'b010; start = 1'b1; num_steps = 8'd1;
        tick();
        seed_we = 1'b0; start = 1'b0;
        checks++;
        if (out_data !== 3'b011 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat1: got data=%b busy=%b expected 011/1", out_data, busy);
        end
        tick();
        checks++;
        if (out_data !== 3'b111 || busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_ignore: got data=%b busy=%b v=%b expected 111/1/1", out_data, busy, out_valid);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== 3'b110 || period !== 8'd0) begin
            errors++;
            $display("FAIL mid_clr: got busy=%b v=%b done=%b data=%b period=%0d expected 0/0/0/110/0",
                     busy, out_valid, done, out_data, period);
        end
    endtask

    task automatic test_zero_steps();
        start = 1'b1; num_steps = 8'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 3'b110) begin
            errors++;
            $display("FAIL zero_steps: got done=%b v=%b busy=%b data=%b expected 1/0/0/110", done, out_valid, busy, out_data);
        end
        tick();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || out_data !== 3'b110) begin
            errors++;
            $display("FAIL zero_steps_after: got done=%b v=%b data=%b expected 0/0/110", done, out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_full_period("full");
        test_seed_load();
        test_zero_seed();
        test_backpressure();
        test_clr_midrun();
        test_zero_steps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
